// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: head slot plus one skid slot, FIFO order,
// synchronous flush, freeze, and bubbles that always carry all-zero control bits.
// Optional stall counter is built only when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_b,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              freeze,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_a;
    logic [DATA_W-1:0] r_main_b;
    logic [DEST_W-1:0] r_main_dest;

    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_a;
    logic [DATA_W-1:0] r_skid_b;
    logic [DEST_W-1:0] r_skid_dest;

    logic w_accept;
    logic w_emit;

    // Handshake: a transfer happens on an edge where valid & ready are both high
    // on that side. in_ready depends only on registered state and freeze, never
    // on out_ready; freeze masks both sides so nothing moves while it is high.
    assign in_ready  = ~r_skid_valid & ~freeze;
    assign out_valid = r_main_valid & ~freeze;
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = out_valid & out_ready;

    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data_a = r_main_a;
    assign out_data_b = r_main_b;
    assign out_dest   = r_main_dest;
    assign occupancy  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_dest  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_dest  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!freeze) begin
            if (!r_main_valid || w_emit) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_main_a     <= r_skid_a;
                    r_main_b     <= r_skid_b;
                    r_main_dest  <= r_skid_dest;
                    r_skid_valid <= w_accept;
                    if (w_accept) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_a    <= in_data_a;
                        r_skid_b    <= in_data_b;
                        r_skid_dest <= in_dest;
                    end
                end else begin
                    r_main_valid <= w_accept;
                    if (w_accept) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_a    <= in_data_a;
                        r_main_b    <= in_data_b;
                        r_main_dest <= in_dest;
                    end
                end
            end else if (w_accept) begin
                // Head is held downstream; park the new entry behind it.
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= in_ctrl;
                r_skid_a     <= in_data_a;
                r_skid_b     <= in_data_b;
                r_skid_dest  <= in_dest;
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Counts cycles a valid head is blocked by downstream; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !freeze && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
